// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing helper, frame constants, FSM state types
// and the word-to-byte selector used by the word transmitter.
package uart_pkg;

   localparam int unsigned FRAME_BITS   = 10;
   localparam logic [7:0]  TERM_DEFAULT = 8'h0A;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic {
      W_IDLE,
      W_SEND
   } word_state_e;

   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

   // Byte 0 is the MSB byte of the word; any index past 3 yields the terminator.
   function automatic logic [7:0] word_byte(input logic [31:0] w,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  term);
      logic [7:0] b;
      case (idx)
         3'd0:    b = w[31:24];
         3'd1:    b = w[23:16];
         3'd2:    b = w[15:8];
         3'd3:    b = w[7:0];
         default: b = term;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start presented on the done cycle chains the next
// frame directly behind the current stop bit.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int unsigned CW            = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST        = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_DATA_BIT = 3'(FRAME_BITS - 3);

   if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
   end

   tx_state_e       state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      bit_idx, bit_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic            tx_nxt, done_nxt;
   logic            last;

   assign last = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shreg   <= shreg_nxt;
         tx      <= tx_nxt;
         done    <= done_nxt;
      end
   end

   // Baud counter only runs inside a frame and wraps at every bit boundary.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      case (state)
         TX_IDLE: begin
            if (start) begin
               state_nxt = TX_START;
               cnt_nxt   = '0;
               shreg_nxt = data;
            end
         end
         TX_START: begin
            if (last) begin
               state_nxt = TX_DATA;
               cnt_nxt   = '0;
               bit_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         TX_DATA: begin
            if (last) begin
               cnt_nxt   = '0;
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bit_idx == LAST_DATA_BIT) begin
                  state_nxt = TX_STOP;
               end else begin
                  bit_nxt = bit_idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         TX_STOP: begin
            if (last) begin
               cnt_nxt = '0;
               if (start) begin
                  state_nxt = TX_START;
                  shreg_nxt = data;
               end else begin
                  state_nxt = TX_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

   // Outputs are decoded from next state so tx and done stay registered.
   always_comb begin
      tx_nxt   = 1'b1;
      done_nxt = 1'b0;
      case (state_nxt)
         TX_START: tx_nxt = 1'b0;
         TX_DATA:  tx_nxt = shreg_nxt[0];
         TX_STOP:  done_nxt = (cnt_nxt == LAST);
         default:  tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: rtl/uart_word_tx.sv
// Sends a 32-bit word as four 8N1 frames, MSB byte first, optionally followed
// by a terminator byte. Frames within a word run back-to-back.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned SEND_TERM = 1,
   parameter logic [7:0]  TERM_BYTE = TERM_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned NBYTES       = (SEND_TERM != 0) ? 5 : 4;
   localparam logic [2:0]  LAST_IDX     = 3'(NBYTES - 1);

   word_state_e  state, state_nxt;
   logic [31:0]  word_q, word_nxt;
   logic [2:0]   byte_idx, idx_nxt;
   logic         byte_start;
   logic [7:0]   byte_data;
   logic         byte_done;
   logic         accept;
   logic         ready_nxt, busy_nxt;

   assign accept = word_valid & word_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= W_IDLE;
         word_q     <= '0;
         byte_idx   <= '0;
         word_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         word_q     <= word_nxt;
         byte_idx   <= idx_nxt;
         word_ready <= ready_nxt;
         busy       <= busy_nxt;
      end
   end

   // The byte advance happens in the done cycle so the engine can chain frames.
   always_comb begin
      state_nxt  = state;
      word_nxt   = word_q;
      idx_nxt    = byte_idx;
      byte_start = 1'b0;
      byte_data  = word_in[31:24];
      case (state)
         W_IDLE: begin
            if (accept) begin
               state_nxt  = W_SEND;
               word_nxt   = word_in;
               idx_nxt    = 3'd0;
               byte_start = 1'b1;
               byte_data  = word_in[31:24];
            end
         end
         W_SEND: begin
            if (byte_done) begin
               if (byte_idx != LAST_IDX) begin
                  idx_nxt    = byte_idx + 3'd1;
                  byte_start = 1'b1;
                  byte_data  = word_byte(word_q, byte_idx + 3'd1, TERM_BYTE);
               end else begin
                  state_nxt = W_IDLE;
               end
            end
         end
         default: state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      ready_nxt = (state_nxt == W_IDLE);
      busy_nxt  = ~ready_nxt;
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk   (clk),
      .rst_n (rst_n),
      .start (byte_start),
      .data  (byte_data),
      .tx    (tx),
      .done  (byte_done)
   );

endmodule
